// File: rtl/tlm_pkg.sv
// Shared definitions for the telemetry transmitter.
// Holds the frame header constants, the frame length, the state enums for the
// frame and UART FSMs, and the byte-select helper that maps a byte index onto
// the snapshot readings.
package tlm_pkg;

    localparam logic [7:0] TLM_HDR0   = 8'hAA;
    localparam logic [7:0] TLM_HDR1   = 8'h55;
    localparam int         TLM_NBYTES = 8;

    typedef enum logic [1:0] {
        FR_IDLE = 2'd0,
        FR_SEND = 2'd1,
        FR_WAIT = 2'd2
    } fr_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_XMIT = 1'b1
    } tx_state_t;

    // Byte idx of the frame: two header bytes, then each 12-bit reading as a
    // zero-padded high nibble followed by its low byte.
    function automatic logic [7:0] tlm_frame_byte(
        input logic [2:0]  idx,
        input logic [11:0] batt,
        input logic [11:0] curr,
        input logic [11:0] torque
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = TLM_HDR0;
            3'd1:    b = TLM_HDR1;
            3'd2:    b = {4'h0, batt[11:8]};
            3'd3:    b = batt[7:0];
            3'd4:    b = {4'h0, curr[11:8]};
            3'd5:    b = curr[7:0];
            3'd6:    b = {4'h0, torque[11:8]};
            3'd7:    b = torque[7:0];
            default: b = TLM_HDR0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter.
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-high reset (forces TX high at once)
//   trmt     - one-cycle request to send tx_data (honoured only when idle)
//   tx_data  - byte to send, sampled with trmt
//   TX       - serial line, idle high, driven straight from the shift register
//   tx_done  - registered one-cycle pulse after the stop bit has completed
module uart_tx
    import tlm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int                 CNT_W     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0]   BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    tx_state_t         state_q, state_d;
    logic [9:0]        shift_q, shift_d;
    logic [CNT_W-1:0]  baud_q,  baud_d;
    logic [3:0]        bit_q,   bit_d;
    logic              done_q,  done_d;

    // Next-state logic: load on trmt, shift at each baud terminal count, and
    // finish once the tenth (stop) bit has held for a full bit period.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (trmt) begin
                    shift_d = {1'b1, tx_data, 1'b0};
                    baud_d  = {CNT_W{1'b0}};
                    bit_d   = 4'd0;
                    state_d = TX_XMIT;
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_XMIT: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = {CNT_W{1'b0}};
                    // Shifting in ones leaves the line high once the frame is out.
                    shift_d = {1'b1, shift_q[9:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd9) begin
                        state_d = TX_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = TX_XMIT;
                    end
                end else begin
                    baud_d  = baud_q + CNT_W'(1'b1);
                    state_d = TX_XMIT;
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    // State and datapath registers; the all-ones shift reset value is what
    // drives TX high asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TX_IDLE;
            shift_q <= 10'h3FF;
            baud_q  <= {CNT_W{1'b0}};
            bit_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
        end
    end

    assign TX      = shift_q[0];
    assign tx_done = done_q;

endmodule

// File: rtl/telemetry_tx.sv
// Telemetry frame transmitter.
// On a request it snapshots battery voltage, motor current and pedal torque,
// then sends the 8-byte frame AA 55 bH bL cH cL tH tL as 8N1 UART.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   snd_tlm   - one-cycle frame request (ignored while busy)
//   batt, curr, torque - 12-bit readings, captured on an accepted request
//   TX        - UART serial output, idle high
//   tlm_busy  - high while a frame is in progress
//   frm_done  - one-cycle pulse after the final stop bit
module telemetry_tx
    import tlm_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        snd_tlm,
    input  logic [11:0] batt,
    input  logic [11:0] curr,
    input  logic [11:0] torque,
    output logic        TX,
    output logic        tlm_busy,
    output logic        frm_done
);

    localparam logic [2:0] LAST_IDX = 3'(TLM_NBYTES - 1);

    fr_state_t    state_q,    state_d;
    logic [2:0]   idx_q,      idx_d;
    logic [11:0]  batt_q,     batt_d;
    logic [11:0]  curr_q,     curr_d;
    logic [11:0]  torque_q,   torque_d;
    logic         frm_done_q, frm_done_d;
    logic         busy_q,     busy_d;
    logic         trmt_s;
    logic         tx_done_s;
    logic [7:0]   tx_byte_s;

    // Frame sequencing: accept a request only when idle, hand one byte at a
    // time to the UART and wait for it to finish before the next.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        batt_d     = batt_q;
        curr_d     = curr_q;
        torque_d   = torque_q;
        frm_done_d = 1'b0;
        trmt_s     = 1'b0;
        case (state_q)
            FR_IDLE: begin
                if (snd_tlm) begin
                    batt_d   = batt;
                    curr_d   = curr;
                    torque_d = torque;
                    idx_d    = 3'd0;
                    state_d  = FR_SEND;
                end else begin
                    state_d  = FR_IDLE;
                end
            end
            FR_SEND: begin
                trmt_s  = 1'b1;
                state_d = FR_WAIT;
            end
            FR_WAIT: begin
                if (tx_done_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d    = FR_IDLE;
                        frm_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = FR_SEND;
                    end
                end else begin
                    state_d = FR_WAIT;
                end
            end
            default: begin
                state_d = FR_IDLE;
            end
        endcase
        // Registering busy from the next state keeps it equal to
        // (state != FR_IDLE) while coming straight off a flop.
        busy_d = (state_d != FR_IDLE);
    end

    // Frame FSM, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FR_IDLE;
            idx_q      <= 3'd0;
            batt_q     <= 12'h000;
            curr_q     <= 12'h000;
            torque_q   <= 12'h000;
            frm_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            batt_q     <= batt_d;
            curr_q     <= curr_d;
            torque_q   <= torque_d;
            frm_done_q <= frm_done_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_byte_s = tlm_frame_byte(idx_q, batt_q, curr_q, torque_q);

    uart_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart_tx (
        .clk     (clk),
        .rst     (rst),
        .trmt    (trmt_s),
        .tx_data (tx_byte_s),
        .TX      (TX),
        .tx_done (tx_done_s)
    );

    assign tlm_busy = busy_q;
    assign frm_done = frm_done_q;

endmodule

// File: tb/tb_telemetry_tx.sv
module tb_telemetry_tx;

    localparam int B         = 8;
    localparam int BYTE_P    = 10 * B + 2;
    localparam int FRAME_LEN = 1 + 8 * BYTE_P;   // request cycle to frm_done cycle

    logic        clk;
    logic        rst;
    logic        snd_tlm;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] torque;
    logic        TX;
    logic        tlm_busy;
    logic        frm_done;

    int n_assert = 0;
    int n_fail   = 0;

    telemetry_tx #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst      (rst),
        .snd_tlm  (snd_tlm),
        .batt     (batt),
        .curr     (curr),
        .torque   (torque),
        .TX       (TX),
        .tlm_busy (tlm_busy),
        .frm_done (frm_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described only by the edge at which it was accepted and its
    // eight bytes; outputs follow from the offset into the frame.
    int         edge_cnt = 0;
    bit         m_act    = 1'b0;
    int         m_edge   = 0;
    logic [7:0] m_frame [8];

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            if (rst) begin
                m_act = 1'b0;
            end else if (snd_tlm && (!m_act || (edge_cnt - m_edge) >= FRAME_LEN)) begin
                m_act      = 1'b1;
                m_edge     = edge_cnt;
                m_frame[0] = 8'hAA;
                m_frame[1] = 8'h55;
                m_frame[2] = {4'h0, batt[11:8]};
                m_frame[3] = batt[7:0];
                m_frame[4] = {4'h0, curr[11:8]};
                m_frame[5] = curr[7:0];
                m_frame[6] = {4'h0, torque[11:8]};
                m_frame[7] = torque[7:0];
            end
        end
    end

    function automatic void model_out(output logic e_tx, output logic e_busy, output logic e_done);
        int o, p, k, r, bi;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        if (m_act) begin
            o = edge_cnt - m_edge + 1;       // offset of the current cycle from the request cycle
            e_busy = (o >= 1) && (o < FRAME_LEN);
            e_done = (o == FRAME_LEN);
            if (o >= 2 && o < FRAME_LEN) begin
                p = o - 2;
                k = p / BYTE_P;
                r = p % BYTE_P;
                if (k < 8 && r < 10 * B) begin
                    bi = r / B;
                    if (bi == 0)      e_tx = 1'b0;
                    else if (bi <= 8) e_tx = m_frame[k][bi-1];
                    else              e_tx = 1'b1;
                end
            end
        end
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    int done_cnt = 0;
    initial begin
        logic e_tx, e_busy, e_done;
        forever begin
            @(negedge clk);
            if (rst) begin
                e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
            end else begin
                model_out(e_tx, e_busy, e_done);
            end
            check("cyc TX", {31'd0, TX}, {31'd0, e_tx});
            check("cyc tlm_busy", {31'd0, tlm_busy}, {31'd0, e_busy});
            check("cyc frm_done", {31'd0, frm_done}, {31'd0, e_done});
            if (!rst && frm_done === 1'b1) done_cnt++;
        end
    end

    // ---------------- serial decoder ----------------
    logic [7:0] rx_buf [8];
    bit         rx_ok;

    task automatic rx_frame();
        int w;
        rx_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = 0;
            @(negedge clk);
            while (TX !== 1'b0 && w < 400) begin
                @(negedge clk);
                w++;
            end
            if (w >= 400) begin
                rx_ok = 1'b0;
                return;
            end
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(negedge clk);
                rx_buf[k][i] = TX;
            end
            repeat (B) @(negedge clk);
            if (TX !== 1'b1) rx_ok = 1'b0;
        end
    endtask

    task automatic check_rx(input string tag, input logic [63:0] exp);
        logic [63:0] e;
        e = exp;
        check({tag, " rx complete"}, {31'd0, rx_ok}, 32'd1);
        for (int k = 0; k < 8; k++)
            check($sformatf("%s byte%0d", tag, k), {24'd0, rx_buf[k]}, {24'd0, e[63 - 8*k -: 8]});
    endtask

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        batt = b; curr = c; torque = t; snd_tlm = 1'b1;
        step();
        snd_tlm = 1'b0;
    endtask

    // Step until frm_done, counting cycles from the request cycle.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (frm_done !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; snd_tlm = 1'b0; batt = 12'h000; curr = 12'h000; torque = 12'h000;

        // reset state
        repeat (3) step();
        check("reset TX", {31'd0, TX}, 32'd1);
        check("reset tlm_busy", {31'd0, tlm_busy}, 32'd0);
        check("reset frm_done", {31'd0, frm_done}, 32'd0);
        rst = 1'b0;
        repeat (1000) step();
        check("idle TX", {31'd0, TX}, 32'd1);

        // frame 1 with an ignored mid-frame request
        request(12'hABC, 12'h123, 12'hFFF);
        check("busy s+1", {31'd0, tlm_busy}, 32'd1);
        fork
            rx_frame();
            begin
                n = 1;
                while (frm_done !== 1'b1 && n < 2000) begin
                    if (n == 300) begin
                        batt = 12'h000; curr = 12'h000; torque = 12'h000; snd_tlm = 1'b1;
                    end else begin
                        snd_tlm = 1'b0;
                    end
                    step();
                    n++;
                end
            end
        join
        check("f1 frm_done latency", n, 32'd657);
        check("f1 busy falls with done", {31'd0, tlm_busy}, 32'd0);
        check_rx("f1", 64'hAA55_0ABC_0123_0FFF);

        // back-to-back request in the frm_done cycle
        batt = 12'h5A5; curr = 12'h0F0; torque = 12'h00F; snd_tlm = 1'b1;
        fork
            rx_frame();
            begin
                step();
                snd_tlm = 1'b0;
                batt = 12'h111; curr = 12'h222; torque = 12'h333;
                check("f2 TX s+1", {31'd0, TX}, 32'd1);
                step();
                check("f2 start bit s+2", {31'd0, TX}, 32'd0);
                check("f1 single frm_done", done_cnt, 32'd1);
                wait_done(2, n);
            end
        join
        check("f2 frm_done latency", n, 32'd657);
        check_rx("f2", 64'hAA55_05A5_00F0_000F);
        repeat (5) step();

        // reset during data bits of byte 3
        request(12'h321, 12'h654, 12'h987);
        repeat (269) step();
        #2 rst = 1'b1;
        #1;
        check("rst TX high", {31'd0, TX}, 32'd1);
        check("rst tlm_busy", {31'd0, tlm_busy}, 32'd0);
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        check("post-rst TX idle", {31'd0, TX}, 32'd1);

        // recovery frame
        request(12'h7E1, 12'h800, 12'h04C);
        fork
            rx_frame();
            wait_done(1, n);
        join
        check("f4 frm_done latency", n, 32'd657);
        check_rx("f4", 64'hAA55_07E1_0800_004C);
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
